fpga_data_sink: RTL
===================

FPGA_DATA_SINK -- requirements
Module: fpga_data_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, capture FIFO depth in bytes (power of two, 4..1024).
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have Avalon-MM slave ports: avs_address in 2; avs_chipselect in 1; avs_read in 1; avs_write_n in 1; avs_writedata in 32; avs_readdata out 32.
REQ-005 SHALL have AXI4-Stream slave ports: axis4_s_tdata in 8; axis4_s_tvalid in 1; axis4_s_tlast in 1; axis4_s_tready out 1.

Function
REQ-006 Register map SHALL be: 0 CTRL (R/W), 1 STAT (RO), 2 DATA (RO, pops), 3 INFO (RO).
REQ-007 CTRL SHALL define: [0] arm; [1] flush (self-clearing, reads 0); [31:16] byte limit (0 = unlimited).
REQ-008 STAT SHALL read: [0] armed; [1] done; [2] FIFO empty; [3] FIFO full; [4] tlast seen; [31:16] FIFO level.
REQ-009 INFO SHALL read: [15:0] captured byte count; [31:16] checksum (see REQ-021).
REQ-010 avs_readdata SHALL be combinational from avs_address. DATA SHALL read {24'h0, FIFO head} (first-word-fall-through), or 32'h0 when empty.
REQ-011 A pop SHALL occur when avs_chipselect && avs_read && avs_address==2 && !empty. Level SHALL decrement next cycle. A pop when empty SHALL change nothing.
REQ-012 The FSM SHALL have states IDLE, ARMED and DONE, encoded 2'b00, 2'b01 and 2'b10.
REQ-013 A CTRL write with arm=1 from IDLE or DONE SHALL enter ARMED next cycle. The same write SHALL clear byte count, checksum and tlast-seen.
REQ-014 A CTRL write with arm=0 in ARMED SHALL return to IDLE. FIFO contents SHALL be kept.
REQ-015 axis4_s_tready SHALL equal (state==ARMED) && !full && !(flush write this cycle).
REQ-016 A byte SHALL be accepted on tvalid && tready. It SHALL be pushed, and count and checksum SHALL update, on the same edge.
REQ-017 An accepted byte with tlast=1 SHALL move ARMED->DONE next cycle and set tlast-seen.
REQ-018 An accepted byte that makes count equal a nonzero limit SHALL move ARMED->DONE next cycle. tready SHALL be 0 in DONE.
REQ-019 A simultaneous push and pop SHALL be legal when the FIFO is not full; level SHALL be unchanged. When full, the pop SHALL proceed and the push SHALL be blocked by tready=0 in that cycle.
REQ-020 Flush SHALL empty the FIFO next cycle. Flush SHALL override a concurrent pop. Count, checksum and state SHALL be unaffected.
REQ-021 Checksum SHALL be the 16-bit modular sum of accepted bytes, wrapping at 16'hFFFF. Count SHALL saturate at 16'hFFFF.
REQ-022 CTRL bit 0 SHALL be cleared by hardware on entry to DONE. CTRL SHALL read back the last written value otherwise.

Reset
REQ-023 On reset, state SHALL be IDLE, CTRL=0, FIFO empty, count=0, checksum=0, tlast-seen=0 and axis4_s_tready=0.
REQ-024 Reset mid-capture SHALL discard FIFO contents. The first post-reset cycle SHALL show STAT=32'h0000_0004.

Configuration
REQ-025 Macro FPGA_DATA_SINK_CSUM_EN SHALL gate the checksum logic. When defined, REQ-021 applies. When undefined, no checksum logic SHALL exist and INFO[31:16] SHALL read 0.

Structure
REQ-026 Package fpga_stream_pkg SHALL hold register-address constants, CTRL/STAT bit indices and the FSM state encoding.
REQ-027 FIFO storage SHALL be a sub-module fpga_data_sink_fifo (sync FWFT FIFO with push/pop/flush, level, empty and full).

Verification
REQ-028 Bench SHALL: arm with limit 0; send bytes 01..05 with tlast on 05 -> DONE, count=5, level=5, checksum=16'h000F, five DATA reads return 01..05 then empty.
REQ-029 Bench SHALL: arm with limit 3; stream 10 bytes with tvalid held high -> exactly 3 accepted, DONE, tready=0 thereafter.
REQ-030 Bench SHALL: FIFO_DEPTH=64; stream 70 bytes with no reads -> tready drops at level 64; one DATA read -> exactly one more byte accepted.
REQ-031 Bench SHALL: flush while full and streaming -> level 0 next cycle, no byte accepted in the flush cycle, count unchanged.
REQ-032 Bench SHALL: 300 bytes of 8'hFF (limit 0) -> checksum=16'h2AD4 with FPGA_DATA_SINK_CSUM_EN, 0 without.
REQ-033 Bench SHALL: assert reset after 2 bytes accepted -> STAT=32'h0000_0004, INFO=0 and tready=0.

Source files
------------

// File: rtl/fpga_stream_pkg.sv
// Shared register map, CTRL/STAT bit positions and FSM encoding for fpga_data_sink.
package fpga_stream_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DATA = 2'd2;
  localparam logic [1:0] ADDR_INFO = 2'd3;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_FLUSH     = 1;
  localparam int CTRL_LIMIT_LSB = 16;

  localparam int STAT_ARMED     = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_TLAST     = 4;
  localparam int STAT_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Byte counter holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fpga_data_sink_if.sv
// Avalon-MM register bus plus AXI4-Stream byte input of the data sink, bundled for the driving side.
// Handshake: a byte transfers on the rising edge where axis4_s_tvalid && axis4_s_tready are both high.
interface fpga_data_sink_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [7:0]  axis4_s_tdata;
  logic        axis4_s_tvalid;
  logic        axis4_s_tlast;
  logic        axis4_s_tready;

  modport master (
    output avs_address, avs_chipselect, avs_read, avs_write_n, avs_writedata,
    output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    input  avs_readdata, axis4_s_tready
  );

  modport slave (
    input  avs_address, avs_chipselect, avs_read, avs_write_n, avs_writedata,
    input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    output avs_readdata, axis4_s_tready
  );
endinterface

// File: rtl/fpga_data_sink_fifo.sv
// Synchronous first-word-fall-through byte FIFO with push, pop, flush, level, empty and full.
module fpga_data_sink_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [7:0]   push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [7:0]   head,
  output logic [AW:0]  level,
  output logic         empty,
  output logic         full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Flush wins over any concurrent pop; the storage itself is left as is.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fpga_data_sink.sv
// Byte-stream capture sink: AXI4-Stream bytes into a FIFO, drained and controlled over Avalon-MM.
// Optional checksum logic is built only when FPGA_DATA_SINK_CSUM_EN is defined.
module fpga_data_sink
  import fpga_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic [7:0]  axis4_s_tdata,
  input  logic        axis4_s_tvalid,
  input  logic        axis4_s_tlast,
  output logic        axis4_s_tready,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t      state;
  logic [31:0] ctrl;
  logic [15:0] count;
  logic [15:0] csum;
  logic        tlast_seen;
  logic [7:0]  head;
  logic [AW:0] level;
  logic        empty;
  logic        full;

  logic ctrl_wr, flush_wr, arm_start, pop, accept, hit_limit;
  logic [15:0] next_count;

  assign ctrl_wr    = avs_chipselect && !avs_write_n && (avs_address == ADDR_CTRL);
  assign flush_wr   = ctrl_wr && avs_writedata[CTRL_FLUSH];
  assign arm_start  = ctrl_wr && avs_writedata[CTRL_ARM] && (state != ST_ARMED);
  assign pop        = avs_chipselect && avs_read && (avs_address == ADDR_DATA);
  assign axis4_s_tready = (state == ST_ARMED) && !full && !flush_wr;
  assign accept     = axis4_s_tvalid && axis4_s_tready;
  assign next_count = sat_inc16(count);
  assign hit_limit  = (ctrl[CTRL_LIMIT_LSB +: 16] != 16'd0) &&
                      (next_count == ctrl[CTRL_LIMIT_LSB +: 16]);
  assign dbg_state  = state;

  fpga_data_sink_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (axis4_s_tdata),
    .pop       (pop),
    .flush     (flush_wr),
    .head      (head),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  // Flush is a strobe, so it is never stored; arm drops by itself when capture completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ctrl       <= '0;
      count      <= '0;
      tlast_seen <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= avs_writedata & ~(32'h1 << CTRL_FLUSH);
      case (state)
        ST_ARMED: begin
          if (accept) begin
            count <= next_count;
            if (axis4_s_tlast) tlast_seen <= 1'b1;
          end
          if (ctrl_wr && !avs_writedata[CTRL_ARM]) begin
            state <= ST_IDLE;
          end else if (accept && (axis4_s_tlast || hit_limit)) begin
            state          <= ST_DONE;
            ctrl[CTRL_ARM] <= 1'b0;
          end
        end
        default: begin
          if (arm_start) begin
            state      <= ST_ARMED;
            count      <= '0;
            tlast_seen <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FPGA_DATA_SINK_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset || arm_start) csum <= '0;
    else if (accept)        csum <= csum + {8'h00, axis4_s_tdata};
  end
`else
  assign csum = '0;
`endif

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      ADDR_CTRL: avs_readdata = ctrl;
      ADDR_STAT: begin
        avs_readdata[STAT_ARMED] = (state == ST_ARMED);
        avs_readdata[STAT_DONE]  = (state == ST_DONE);
        avs_readdata[STAT_EMPTY] = empty;
        avs_readdata[STAT_FULL]  = full;
        avs_readdata[STAT_TLAST] = tlast_seen;
        avs_readdata[STAT_LEVEL_LSB +: 16] = 16'(level);
      end
      ADDR_DATA: if (!empty) avs_readdata[7:0] = head;
      ADDR_INFO: avs_readdata = {csum, count};
      default:   avs_readdata = '0;
    endcase
  end

endmodule
